// File: rtl/catchable_object_ctrl.sv
// ---------------------------------------------------------------------------
// catchable_object_ctrl
//
// Per-object controller for N_HOOKS independent hooks. Detects when a hook
// tip lands inside the object's box, hands ownership to the lowest-numbered
// hook that hit, and drags the object along that hook's direction one step
// every TICK_DIV cycles. The object is collected, with a one-cycle score
// pulse, when the owner hook gets home or after MAX_STEPS steps. It is
// destroyed without scoring if the owner hook detonates.
//
// Ports
//   Clk                system clock
//   reset              asynchronous, active-high reset
//   is_new_game_start  synchronous restart to VISIBLE (overrides everything)
//   spawn_x/spawn_y    object home position (top-left corner)
//   tail_x/tail_y      packed hook tip coordinates, hook i at [10i+9:10i]
//   hook_out           hook i is extending and may catch
//   hook_dir           packed 4-bit direction code per hook (0..10)
//   hook_home          hook i fully retracted
//   explode            hook i detonates its load
//   DrawX/DrawY        current VGA pixel
//   is_obj             pixel lies inside the visible object
//   rom_addr           sprite ROM address for the pixel (0 when !is_obj)
//   catch_vec          one-hot owner while CAUGHT, else 0
//   score_pulse        one-cycle pulse on collection
//   score_owner        owner index while score_pulse, else 0
//   score_value        VALUE while score_pulse, else 0
//   destroyed          object no longer on the map
//   state_out          VISIBLE=0, CAUGHT=1, COLLECT=2, GONE=3
// ---------------------------------------------------------------------------
module catchable_object_ctrl #(
  parameter int           N_HOOKS   = 2,
  parameter logic [9:0]   OBJ_LEN   = 10'd40,
  parameter logic [9:0]   OBJ_WID   = 10'd30,
  parameter int           TICK_DIV  = 4000000,
  parameter logic [9:0]   MAX_STEPS = 10'd80,
  parameter logic [15:0]  VALUE     = 16'd100
) (
  input  logic                   Clk,
  input  logic                   reset,
  input  logic                   is_new_game_start,
  input  logic [9:0]             spawn_x,
  input  logic [9:0]             spawn_y,
  input  logic [10*N_HOOKS-1:0]  tail_x,
  input  logic [10*N_HOOKS-1:0]  tail_y,
  input  logic [N_HOOKS-1:0]     hook_out,
  input  logic [4*N_HOOKS-1:0]   hook_dir,
  input  logic [N_HOOKS-1:0]     hook_home,
  input  logic [N_HOOKS-1:0]     explode,
  input  logic [9:0]             DrawX,
  input  logic [9:0]             DrawY,
  output logic                   is_obj,
  output logic [18:0]            rom_addr,
  output logic [N_HOOKS-1:0]     catch_vec,
  output logic                   score_pulse,
  output logic [2:0]             score_owner,
  output logic [15:0]            score_value,
  output logic                   destroyed,
  output logic [1:0]             state_out
);

  typedef enum logic [1:0] {
    ST_VISIBLE = 2'd0,
    ST_CAUGHT  = 2'd1,
    ST_COLLECT = 2'd2,
    ST_GONE    = 2'd3
  } state_t;

  // A divider of 1 still needs a one-bit counter that simply wraps every cycle.
  localparam int         TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  // Registered hook inputs: the hit test looks at last cycle's tips.
  logic [10*N_HOOKS-1:0] tail_x_q, tail_y_q;
  logic [N_HOOKS-1:0]    hook_out_q;
  logic [4*N_HOOKS-1:0]  hook_dir_q;

  state_t        state_q, state_d;
  logic [2:0]    owner_q, owner_d;
  logic [9:0]    dx_q, dx_d, dy_q, dy_d;
  logic [9:0]    step_q, step_d;
  logic [TW-1:0] tick_q, tick_d;
  // Accumulated displacement from spawn; cur = spawn + off keeps the object
  // tracking spawn while VISIBLE (off is zero there) without loading spawn
  // into a register under asynchronous reset.
  logic [9:0]    off_x_q, off_x_d, off_y_q, off_y_d;

  logic [9:0]         cur_x, cur_y;
  logic [N_HOOKS-1:0] hit_vec;
  logic [N_HOOKS-1:0] owner_oh;
  logic               hit_any;
  logic [2:0]         hit_idx;
  logic [3:0]         hit_dir;
  logic [9:0]         dir_dx, dir_dy;
  logic               explode_own, home_own;
  logic               tick_wrap;

  // -------------------------------------------------------------------------
  // Current position
  // -------------------------------------------------------------------------
  always_comb begin
    cur_x = spawn_x + off_x_q;
    cur_y = spawn_y + off_y_q;
    if (state_q == ST_GONE) begin
      cur_x = '0;
      cur_y = '0;
    end
  end

  // -------------------------------------------------------------------------
  // Per-hook hit test (inclusive box) and owner one-hot decode
  // -------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < N_HOOKS; gi++) begin : g_hook
      logic [9:0] tx, ty;
      logic       in_x, in_y;
      assign tx   = tail_x_q[10*gi +: 10];
      assign ty   = tail_y_q[10*gi +: 10];
      // 11-bit compares so cur+size near the screen edge does not wrap.
      assign in_x = ({1'b0, tx} >= {1'b0, cur_x}) &&
                    ({1'b0, tx} <= ({1'b0, cur_x} + {1'b0, OBJ_LEN}));
      assign in_y = ({1'b0, ty} >= {1'b0, cur_y}) &&
                    ({1'b0, ty} <= ({1'b0, cur_y} + {1'b0, OBJ_WID}));
      assign hit_vec[gi]  = hook_out_q[gi] && in_x && in_y;
      assign owner_oh[gi] = (owner_q == 3'(gi));
    end
  endgenerate

  // Lowest-index hit wins: scan downward so the last match is the lowest.
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    hit_dir = '0;
    for (int i = N_HOOKS - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        hit_any = 1'b1;
        hit_idx = 3'(i);
        hit_dir = hook_dir_q[4*i +: 4];
      end
    end
  end

  // Per-step displacement for the catching hook's direction (two's complement).
  always_comb begin
    dir_dx = 10'd0;
    dir_dy = 10'd0;
    case (hit_dir)
      4'd0:  begin dir_dx = 10'd6;    dir_dy = 10'd0;    end
      4'd1:  begin dir_dx = 10'd6;    dir_dy = -10'sd1;  end
      4'd2:  begin dir_dx = 10'd5;    dir_dy = -10'sd2;  end
      4'd3:  begin dir_dx = 10'd4;    dir_dy = -10'sd3;  end
      4'd4:  begin dir_dx = 10'd2;    dir_dy = -10'sd4;  end
      4'd5:  begin dir_dx = 10'd0;    dir_dy = -10'sd6;  end
      4'd6:  begin dir_dx = -10'sd2;  dir_dy = -10'sd4;  end
      4'd7:  begin dir_dx = -10'sd4;  dir_dy = -10'sd3;  end
      4'd8:  begin dir_dx = -10'sd5;  dir_dy = -10'sd2;  end
      4'd9:  begin dir_dx = -10'sd6;  dir_dy = -10'sd1;  end
      4'd10: begin dir_dx = -10'sd6;  dir_dy = 10'd0;   end
      default: begin dir_dx = 10'd0;  dir_dy = 10'd0;   end
    endcase
  end

  // Only the owner's explode/home matter; other hooks are ignored.
  assign explode_own = |(explode & owner_oh);
  assign home_own    = |(hook_home & owner_oh);
  assign tick_wrap   = (tick_q == TICK_LAST);

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    step_d  = step_q;
    tick_d  = tick_q;
    off_x_d = off_x_q;
    off_y_d = off_y_q;

    case (state_q)
      ST_VISIBLE: begin
        if (hit_any) begin
          state_d = ST_CAUGHT;
          owner_d = hit_idx;
          dx_d    = dir_dx;
          dy_d    = dir_dy;
          step_d  = '0;
          tick_d  = '0;
          off_x_d = '0;
          off_y_d = '0;
        end
      end

      ST_CAUGHT: begin
        if (tick_wrap) begin
          tick_d  = '0;
          step_d  = step_q + 10'd1;
          off_x_d = off_x_q + dx_q;
          off_y_d = off_y_q + dy_q;
        end else begin
          tick_d = tick_q + TW'(1);
        end
        // The step limit is judged on the step count just reached, so the
        // object leaves CAUGHT on the same edge that applies the last step.
        if (explode_own) begin
          state_d = ST_GONE;
        end else if (home_own || (step_d >= MAX_STEPS)) begin
          state_d = ST_COLLECT;
        end
      end

      ST_COLLECT: state_d = ST_GONE;

      default: state_d = ST_GONE;
    endcase

    if (is_new_game_start) begin
      state_d = ST_VISIBLE;
      owner_d = '0;
      dx_d    = '0;
      dy_d    = '0;
      step_d  = '0;
      tick_d  = '0;
      off_x_d = '0;
      off_y_d = '0;
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      tail_x_q   <= '0;
      tail_y_q   <= '0;
      hook_out_q <= '0;
      hook_dir_q <= '0;
      state_q    <= ST_VISIBLE;
      owner_q    <= '0;
      dx_q       <= '0;
      dy_q       <= '0;
      step_q     <= '0;
      tick_q     <= '0;
      off_x_q    <= '0;
      off_y_q    <= '0;
    end else begin
      tail_x_q   <= tail_x;
      tail_y_q   <= tail_y;
      hook_out_q <= hook_out;
      hook_dir_q <= hook_dir;
      state_q    <= state_d;
      owner_q    <= owner_d;
      dx_q       <= dx_d;
      dy_q       <= dy_d;
      step_q     <= step_d;
      tick_q     <= tick_d;
      off_x_q    <= off_x_d;
      off_y_q    <= off_y_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  logic [9:0] rel_x, rel_y;
  logic       pix_in_x, pix_in_y;

  assign rel_x    = DrawX - cur_x;
  assign rel_y    = DrawY - cur_y;
  // Sprite box is half-open so addresses stay inside OBJ_LEN x OBJ_WID.
  assign pix_in_x = ({1'b0, DrawX} >= {1'b0, cur_x}) &&
                    ({1'b0, DrawX} <  ({1'b0, cur_x} + {1'b0, OBJ_LEN}));
  assign pix_in_y = ({1'b0, DrawY} >= {1'b0, cur_y}) &&
                    ({1'b0, DrawY} <  ({1'b0, cur_y} + {1'b0, OBJ_WID}));

  assign is_obj      = (state_q != ST_GONE) && pix_in_x && pix_in_y;
  assign rom_addr    = is_obj ? (19'(rel_y) * 19'(OBJ_LEN) + 19'(rel_x)) : 19'd0;
  assign catch_vec   = (state_q == ST_CAUGHT) ? owner_oh : '0;
  assign score_pulse = (state_q == ST_COLLECT);
  assign score_owner = score_pulse ? owner_q : 3'd0;
  assign score_value = score_pulse ? VALUE : 16'd0;
  assign destroyed   = (state_q == ST_GONE);
  assign state_out   = state_q;

endmodule
